// File: rtl/ctrl_bubble_stage_pkg.sv
// Shared definitions for the ID/EX control-bundle stage: bundle field
// positions, default bundle width / NOP encoding and the sequencer states.
package ctrl_bubble_stage_pkg;

    // Default bundle geometry
    localparam int CTRL_W_DEF = 8;
    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP_DEF = '0;

    // Bit positions of the individual control signals inside the bundle
    localparam int CTRL_BRANCH   = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_ALUOP_HI = 4;
    localparam int CTRL_ALUOP_LO = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_REGWRITE = 0;

    // Bubble sequencer states: BUBBLE means more NOP slots are still owed
    typedef enum logic {
        IDLE   = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    // True when a bundle writes architectural state (register file or memory)
    function automatic logic has_side_effect(input logic [CTRL_W_DEF-1:0] bundle);
        return bundle[CTRL_REGWRITE] | bundle[CTRL_MEMWRITE];
    endfunction

endpackage

// File: rtl/ctrl_bubble_stage_sat_counter.sv
// Saturating event counter: counts inc_i pulses and sticks at all-ones.
module sat_counter
    import ctrl_bubble_stage_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_p1;

    // Increment that refuses to wrap past the maximum value
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] value);
        return (&value) ? value : value + W'(1);
    endfunction

    // Counter register, cleared asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_p1 <= '0;
        end else if (inc_i) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign cnt_o = cnt_p1;

endmodule

// File: rtl/ctrl_bubble_stage.sv
// ID/EX control-bundle pipeline register with squash, stall hold and
// multi-cycle bubble injection. A bubble of length L emits L consecutive
// NOP slots (stalled cycles excluded) and raises hold_o for the L-1 cycles
// that follow the first NOP slot so decode does not advance meanwhile.
module ctrl_bubble_stage
    import ctrl_bubble_stage_pkg::*;
#(
    parameter int                CTRL_W   = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}},
    parameter int                LEN_W    = 2,
    parameter int                STAT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              bubble_req_i,
    input  logic [LEN_W-1:0]  bubble_len_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              valid_o,
    output logic              hold_o,
    output logic [STAT_W-1:0] bubble_cnt_o
);

    // Registered stage contents and sequencer state
    logic [CTRL_W-1:0] ctrl_p1;
    logic              vld_p1;
    state_t            state_p1;
    logic [LEN_W-1:0]  rem_p1;

    // Next-state values
    logic [CTRL_W-1:0] ctrl_nxt;
    logic              vld_nxt;
    state_t            state_nxt;
    logic [LEN_W-1:0]  rem_nxt;
    logic              nop_slot;
    logic [LEN_W-1:0]  req_rem;
    logic              req_start;

    // Remaining slots after the first NOP of a new request
    assign req_rem   = bubble_len_i - LEN_W'(1);
    // A zero-length request is treated as no request at all
    assign req_start = bubble_req_i && (bubble_len_i != '0);

    // Next-state selection in priority order: flush, new bubble,
    // bubble continuation, stall hold, normal load
    always_comb begin
        ctrl_nxt  = ctrl_p1;
        vld_nxt   = vld_p1;
        state_nxt = state_p1;
        rem_nxt   = rem_p1;
        nop_slot  = 1'b0;

        if (flush_i) begin
            ctrl_nxt  = CTRL_NOP;
            vld_nxt   = 1'b0;
            rem_nxt   = '0;
            state_nxt = IDLE;
            nop_slot  = 1'b1;
        end else if ((state_p1 == IDLE) && req_start) begin
            ctrl_nxt  = CTRL_NOP;
            vld_nxt   = 1'b0;
            rem_nxt   = req_rem;
            state_nxt = (req_rem != '0) ? BUBBLE : IDLE;
            nop_slot  = 1'b1;
        end else if ((state_p1 == BUBBLE) && !stall_i) begin
            // bubble_req_i is deliberately ignored here: no extension/restart
            ctrl_nxt  = CTRL_NOP;
            vld_nxt   = 1'b0;
            rem_nxt   = rem_p1 - LEN_W'(1);
            state_nxt = (rem_p1 == LEN_W'(1)) ? IDLE : BUBBLE;
            nop_slot  = 1'b1;
        end else if (stall_i) begin
            ctrl_nxt  = ctrl_p1;
            vld_nxt   = vld_p1;
        end else begin
            ctrl_nxt  = ctrl_i;
            vld_nxt   = valid_i;
        end
    end

    // Stage and sequencer registers, cleared asynchronously to an empty slot
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_p1  <= CTRL_NOP;
            vld_p1   <= 1'b0;
            state_p1 <= IDLE;
            rem_p1   <= '0;
        end else begin
            ctrl_p1  <= ctrl_nxt;
            vld_p1   <= vld_nxt;
            state_p1 <= state_nxt;
            rem_p1   <= rem_nxt;
        end
    end

    sat_counter #(
        .W (STAT_W)
    ) u_bubble_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (nop_slot),
        .cnt_o (bubble_cnt_o)
    );

    assign ctrl_o  = ctrl_p1;
    assign valid_o = vld_p1;
    // Straight from the state register: no input-to-hold_o path
    assign hold_o  = (state_p1 == BUBBLE);

endmodule

// File: doc/ctrl_bubble_stage.md
Name: ctrl_bubble_stage

Overview:
- Parametrised ID/EX control-bundle pipeline register with squash, stall-hold and multi-cycle bubble injection.
- Sits between the control unit / hazard detection and the EX stage.
- Generalises the per-signal flush mux: arbitrary bundle width, configurable NOP encoding, N-cycle bubbles, upstream hold, and a bubble statistics counter.

Parameters:
- CTRL_W, 8, control bundle width (Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite).
- CTRL_NOP, {CTRL_W{1'b0}}, bundle value driven for a squashed or bubble slot.
- LEN_W, 2, width of the bubble length request.
- STAT_W, 16, width of the saturating bubble counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ctrl_i  in  CTRL_W  control bundle from decode.
- valid_i  in  1  decode slot holds a real instruction.
- flush_i  in  1  squash the slot being loaded; abort any bubble sequence.
- stall_i  in  1  hold the register contents.
- bubble_req_i  in  1  request injection of bubble_len_i NOP cycles.
- bubble_len_i  in  LEN_W  number of NOP cycles, 0 = no-op.
- ctrl_o  out  CTRL_W  registered control bundle to EX.
- valid_o  out  1  registered valid.
- hold_o  out  1  registered; upstream must not advance while high.
- bubble_cnt_o  out  STAT_W  saturating count of NOP slots inserted.

Behaviour:
- Reset (asynchronous, any time including mid-bubble):
  - ctrl_o = CTRL_NOP, valid_o = 0, hold_o = 0, bubble_cnt_o = 0.
  - State returns to IDLE, remaining-count = 0.
- States:
  - IDLE: remaining = 0.
  - BUBBLE: remaining > 0.
  - hold_o = (state == BUBBLE), taken from the register with no combinational path from inputs.
- Per-edge priority, highest first:
  1. flush_i:
     - ctrl_o <= CTRL_NOP, valid_o <= 0.
     - remaining <= 0, go to IDLE.
     - bubble_cnt_o increments.
     - Overrides stall_i and bubble_req_i.
  2. IDLE and bubble_req_i and bubble_len_i != 0:
     - ctrl_o <= CTRL_NOP, valid_o <= 0, bubble_cnt_o increments.
     - remaining <= bubble_len_i - 1.
     - Enter BUBBLE if that value is nonzero, else stay IDLE.
     - Overrides stall_i.
  3. BUBBLE and not stall_i:
     - ctrl_o <= CTRL_NOP, valid_o <= 0, bubble_cnt_o increments.
     - remaining decrements; go to IDLE when it reaches 0.
     - bubble_req_i is ignored in BUBBLE (no extension or restart).
  4. stall_i (IDLE or BUBBLE):
     - All registers hold, including remaining and bubble_cnt_o.
  5. Otherwise (IDLE):
     - ctrl_o <= ctrl_i, valid_o <= valid_i.
- Latency and sequencing:
  - One cycle from ctrl_i to ctrl_o.
  - A bubble of length L produces exactly L consecutive NOP slots, not counting stalled cycles.
  - hold_o is high for the L-1 cycles after the first NOP slot.
- bubble_req_i with bubble_len_i = 0 behaves as if the request were absent.
- bubble_cnt_o saturates at all-ones and never wraps.
- Only flush_i and reset can abort a bubble sequence.

Decomposition:
- Shared package holds:
  - Bundle field index constants (CTRL_BRANCH=7, CTRL_MEMREAD=6, CTRL_MEMTOREG=5, CTRL_ALUOP_HI=4, CTRL_ALUOP_LO=3, CTRL_MEMWRITE=2, CTRL_ALUSRC=1, CTRL_REGWRITE=0).
  - Default CTRL_W and CTRL_NOP.
  - State encoding (IDLE, BUBBLE).
- One sub-module, sat_counter (parameter W; inputs inc_i, clk_i, rst_i; output cnt_o), used for bubble_cnt_o.

Test Plan:
- Reset: rst_i=1 mid-stream, then released; ctrl_i=8'hA5, valid_i=1 -> ctrl_o=8'h00, valid_o=0, bubble_cnt_o=0 while in reset; ctrl_o=8'hA5, valid_o=1 one edge after release.
- Flush vs stall: flush_i=1 and stall_i=1 with ctrl_i=8'hFF -> ctrl_o=8'h00, valid_o=0, bubble_cnt_o=1.
- Two-cycle bubble: bubble_req_i=1, bubble_len_i=2, ctrl_i=8'h3C -> two NOP slots; hold_o=1 for exactly 1 cycle; bubble_cnt_o=2; ctrl_o=8'h3C on the third edge.
- Stall during bubble: bubble_len_i=3, stall_i=1 for 2 cycles after the first NOP -> remaining frozen; 3 NOP slots total over 5 cycles; hold_o high for 4 cycles; bubble_cnt_o=3.
- Flush aborts bubble: bubble_len_i=3, flush_i=1 on the second cycle -> IDLE; hold_o drops next edge; bubble_cnt_o=2; normal load resumes next cycle.
- Saturation: STAT_W=2, apply 5 flushes -> bubble_cnt_o sequence 1, 2, 3, 3, 3.
